// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - state_e            : responder FSM states (IDLE / WAIT / RESP)
//   - DMEM_BASE_DEFAULT  : default byte address of word 0
//   - WORD_BYTES         : bytes per memory word (one write-mask bit each)
//   - OFFSET_BITS        : byte-offset bits inside a word (ignored by the array)
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [63:0] DMEM_BASE_DEFAULT = 64'h0000_0000_8000_0000;
    localparam int          WORD_BYTES        = 8;
    localparam int          OFFSET_BITS       = 3;

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Word-organised storage with a byte-masked synchronous write port and a
// registered read port, both acting on the same rising edge. Each byte lane
// is kept in its own array so the per-lane write enable maps directly onto
// block-RAM byte enables. Contents have no reset.
//
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   word index for the write
//   wr_data  in   lane-aligned write data
//   wr_mask  in   byte-lane write enables
//   rd_en    in   read strobe; rd_data updates only when set
//   rd_addr  in   word index for the read
//   rd_data  out  registered read data (holds between reads)
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [63:0]           wr_data,
    input  logic [WORD_BYTES-1:0] wr_mask,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [63:0]           rd_data
);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (wr_en && wr_mask[gi]) begin
                    lane_mem[wr_addr] <= wr_data[gi*8 +: 8];
                end
                if (rd_en) begin
                    lane_rd_reg <= lane_mem[rd_addr];
                end
            end

            assign rd_data[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_resp.sv
// ---------------------------------------------------------------------------
// dmem_resp
// Data-memory responder for the pipeline MEM stage. Accepts one load/store at
// a time over a valid/ready channel, performs a byte-masked write or a 64-bit
// read on a dmem_array, and returns a response LATENCY cycles after
// acceptance. The response is held until the requester takes it.
//
// Parameters:
//   DEPTH    number of 64-bit words (power of two)
//   BASE     byte address of word 0
//   LATENCY  cycles from acceptance to rsp_valid_o (>= 1)
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   req_valid_i  in   request present
//   req_ready_o  out  responder idle and able to accept
//   req_wen_i    in   1 = write, 0 = read
//   req_addr_i   in   byte address, bits [2:0] ignored
//   req_wdata_i  in   lane-aligned write data
//   req_wmask_i  in   byte-lane write enables
//   rsp_valid_o  out  response present
//   rsp_ready_i  in   requester takes the response
//   rsp_rdata_o  out  read data, 0 for writes and errors
//   rsp_err_o    out  address outside [BASE, BASE + 8*DEPTH)
//
// Optional build macro:
//   DMEM_TRACE_EN  when defined, prints one simulation trace line per accepted
//                  request; outputs are unaffected.
// ---------------------------------------------------------------------------
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int          DEPTH   = 4096,
    parameter logic [63:0] BASE    = DMEM_BASE_DEFAULT,
    parameter int          LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wen_i,
    input  logic [63:0]           req_addr_i,
    input  logic [63:0]           req_wdata_i,
    input  logic [WORD_BYTES-1:0] req_wmask_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [63:0]           rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int          AW    = $clog2(DEPTH);
    localparam int          CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] SPAN  = 64'(DEPTH) << OFFSET_BITS;

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               err_reg;
    logic               is_read_reg;

    logic               accept;
    logic [63:0]        offset;
    logic               in_range;
    logic [AW-1:0]      word_idx;
    logic [63:0]        arr_rd_data;

    // Unsigned 64-bit subtraction: an address below BASE wraps to a huge
    // offset and so fails the range check without a separate lower bound.
    assign offset   = req_addr_i - BASE;
    assign in_range = (offset < SPAN);
    assign word_idx = offset[OFFSET_BITS +: AW];

    assign accept   = req_valid_i && (state_reg == IDLE);

    dmem_array #(
        .DEPTH   (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (accept && req_wen_i && in_range),
        .wr_addr (word_idx),
        .wr_data (req_wdata_i),
        .wr_mask (req_wmask_i),
        .rd_en   (accept && !req_wen_i && in_range),
        .rd_addr (word_idx),
        .rd_data (arr_rd_data)
    );

    // State, counter and response flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            is_read_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                err_reg     <= !in_range;
                is_read_reg <= !req_wen_i && in_range;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = (state_reg == RESP);
    assign rsp_err_o   = err_reg;
    // The array's registered read port doubles as the response data register:
    // it only loads on an accepted in-range read, so it stays stable until
    // the next acceptance. The flag masks it to 0 for writes, errors and
    // after reset.
    assign rsp_rdata_o = is_read_reg ? arr_rd_data : 64'd0;

`ifdef DMEM_TRACE_EN
    // Read data is only available one edge after acceptance, so the request
    // is captured and the trace line is printed on the following edge.
    logic [63:0]           trace_cycle_reg;
    logic [63:0]           trace_at_reg;
    logic                  trace_pending_reg;
    logic                  trace_wen_reg;
    logic                  trace_err_reg;
    logic [63:0]           trace_addr_reg;
    logic [63:0]           trace_wdata_reg;
    logic [WORD_BYTES-1:0] trace_mask_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trace_cycle_reg   <= '0;
            trace_at_reg      <= '0;
            trace_pending_reg <= 1'b0;
            trace_wen_reg     <= 1'b0;
            trace_err_reg     <= 1'b0;
            trace_addr_reg    <= '0;
            trace_wdata_reg   <= '0;
            trace_mask_reg    <= '0;
        end else begin
            trace_cycle_reg   <= trace_cycle_reg + 64'd1;
            trace_pending_reg <= accept;
            if (accept) begin
                trace_at_reg    <= trace_cycle_reg;
                trace_wen_reg   <= req_wen_i;
                trace_err_reg   <= !in_range;
                trace_addr_reg  <= req_addr_i;
                trace_wdata_reg <= req_wdata_i;
                trace_mask_reg  <= req_wmask_i;
            end
            if (trace_pending_reg) begin
                if (trace_wen_reg) begin
                    $display("dmem cyc=%0d W addr=%h wdata=%h mask=%h err=%0b",
                             trace_at_reg, trace_addr_reg, trace_wdata_reg,
                             trace_mask_reg, trace_err_reg);
                end else begin
                    $display("dmem cyc=%0d R addr=%h rdata=%h err=%0b",
                             trace_at_reg, trace_addr_reg, rsp_rdata_o,
                             trace_err_reg);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// ---------------------------------------------------------------------------
// tb_dmem_resp
// Directed self-checking bench for dmem_resp. Two instances share the clock:
// index 0 uses LATENCY=1, index 1 uses LATENCY=3 (both DEPTH=4096,
// BASE=0x8000_0000). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dmem_resp;

    logic             clk = 1'b0;
    logic [1:0]       rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_wen;
    logic [1:0][63:0] req_addr;
    logic [1:0][63:0] req_wdata;
    logic [1:0][7:0]  req_wmask;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][63:0] rsp_rdata;
    logic [1:0]       rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_resp #(
        .DEPTH       (4096),
        .BASE        (64'h0000_0000_8000_0000),
        .LATENCY     (1)
    ) dut0 (
        .clk         (clk),
        .rst         (rst[0]),
        .req_valid_i (req_valid[0]),
        .req_ready_o (req_ready[0]),
        .req_wen_i   (req_wen[0]),
        .req_addr_i  (req_addr[0]),
        .req_wdata_i (req_wdata[0]),
        .req_wmask_i (req_wmask[0]),
        .rsp_valid_o (rsp_valid[0]),
        .rsp_ready_i (rsp_ready[0]),
        .rsp_rdata_o (rsp_rdata[0]),
        .rsp_err_o   (rsp_err[0])
    );

    dmem_resp #(
        .DEPTH       (4096),
        .BASE        (64'h0000_0000_8000_0000),
        .LATENCY     (3)
    ) dut1 (
        .clk         (clk),
        .rst         (rst[1]),
        .req_valid_i (req_valid[1]),
        .req_ready_o (req_ready[1]),
        .req_wen_i   (req_wen[1]),
        .req_addr_i  (req_addr[1]),
        .req_wdata_i (req_wdata[1]),
        .req_wmask_i (req_wmask[1]),
        .rsp_valid_o (rsp_valid[1]),
        .rsp_ready_i (rsp_ready[1]),
        .rsp_rdata_o (rsp_rdata[1]),
        .rsp_err_o   (rsp_err[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance i. Called just after a rising edge
    // with the instance idle; returns just after the response handshake edge.
    task automatic txn(input int i, input string tag, input logic wen,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] mask, input logic [63:0] exp_rdata,
                       input logic exp_err, input int hold, output int acc_cyc);
        int lat;
        int exp_lat;
        exp_lat = (i == 0) ? 1 : 3;
        check({tag, " ready_before"}, 64'(req_ready[i]), 64'd1);
        req_valid[i] = 1'b1;
        req_wen[i]   = wen;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wmask[i] = mask;
        rsp_ready[i] = (hold == 0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        // Scramble the request bus: only the acceptance edge may sample it.
        req_valid[i] = 1'b0;
        req_wen[i]   = ~wen;
        req_addr[i]  = ~addr;
        req_wdata[i] = ~wdata;
        req_wmask[i] = ~mask;
        lat = 1;
        while (!rsp_valid[i] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            check({tag, " hold_valid"}, 64'(rsp_valid[i]), 64'd1);
            check({tag, " hold_rdata"}, rsp_rdata[i], exp_rdata);
            check({tag, " hold_err"}, 64'(rsp_err[i]), 64'(exp_err));
            check({tag, " hold_req_ready"}, 64'(req_ready[i]), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready[i] = 1'b1;
        check({tag, " rdata"}, rsp_rdata[i], exp_rdata);
        check({tag, " err"}, 64'(rsp_err[i]), 64'(exp_err));
        @(posedge clk); #1;
        check({tag, " ready_after"}, 64'(req_ready[i]), 64'd1);
        check({tag, " valid_after"}, 64'(rsp_valid[i]), 64'd0);
        $display("txn %s inst=%0d wen=%0b addr=%h rdata=%h err=%0b lat=%0d",
                 tag, i, wen, addr, exp_rdata, exp_err, lat);
    endtask

    initial begin
        int a0, a1, a2, a3;
        rst       = 2'b00;
        req_valid = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset req_ready", 64'(req_ready[i]), 64'd1);
            check("reset rsp_valid", 64'(rsp_valid[i]), 64'd0);
            check("reset rsp_rdata", rsp_rdata[i], 64'd0);
            check("reset rsp_err", 64'(rsp_err[i]), 64'd0);
        end
        rst = 2'b11;
        @(posedge clk); #1;

        // ---------------- LATENCY = 1 ----------------
        txn(0, "wr_full", 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0, 0, a0);
        txn(0, "rd_full", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0, 0, a0);
        txn(0, "wr_part", 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'd0, 1'b0, 0, a0);
        txn(0, "rd_part", 1'b0, 64'h8000_0014, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0, 0, a0);
        txn(0, "wr_mask0", 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0, 0, a0);
        txn(0, "rd_mask0", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0, 0, a0);
        txn(0, "rd_oor_low", 1'b0, 64'h0000_1000, 64'd0, 8'h00, 64'd0, 1'b1, 0, a0);
        txn(0, "wr_oor_end", 1'b1, 64'h8000_8000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 64'd0, 1'b1, 0, a0);
        txn(0, "wr_oor_alias", 1'b1, 64'h8000_8010, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 64'd0, 1'b1, 0, a0);
        txn(0, "rd_after_oor", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0, 0, a0);
        txn(0, "wr_last", 1'b1, 64'h8000_7FF8, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 64'd0, 1'b0, 0, a0);
        txn(0, "rd_last", 1'b0, 64'h8000_7FFF, 64'd0, 8'h00, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 0, a0);
        txn(0, "rd_bp", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 1'b0, 5, a0);

        // ---------------- LATENCY = 3 ----------------
        txn(1, "l3_wr", 1'b1, 64'h8000_0100, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0, 0, a0);
        txn(1, "l3_rd", 1'b0, 64'h8000_0100, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0, 0, a1);
        check("l3 spacing 1", 64'(a1 - a0), 64'd4);
        txn(1, "l3_wr2", 1'b1, 64'h8000_0200, 64'h5555_5555_6666_6666, 8'hFF, 64'd0, 1'b0, 0, a2);
        check("l3 spacing 2", 64'(a2 - a1), 64'd4);
        txn(1, "l3_oor_below", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1, 0, a3);
        check("l3 spacing 3", 64'(a3 - a2), 64'd4);

        // Reset one cycle after acceptance, while the read is still waiting.
        check("midwait ready_before", 64'(req_ready[1]), 64'd1);
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b0;
        req_addr[1]  = 64'h8000_0200;
        req_wmask[1] = 8'h00;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("midwait in_wait ready", 64'(req_ready[1]), 64'd0);
        check("midwait in_wait valid", 64'(rsp_valid[1]), 64'd0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        #1;
        check("midwait rst valid", 64'(rsp_valid[1]), 64'd0);
        check("midwait rst ready", 64'(req_ready[1]), 64'd1);
        check("midwait rst rdata", rsp_rdata[1], 64'd0);
        check("midwait rst err", 64'(rsp_err[1]), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midwait held valid", 64'(rsp_valid[1]), 64'd0);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        check("midwait release ready", 64'(req_ready[1]), 64'd1);
        check("midwait release valid", 64'(rsp_valid[1]), 64'd0);
        txn(1, "l3_rd_after_rst", 1'b0, 64'h8000_0200, 64'd0, 8'h00, 64'h5555_5555_6666_6666, 1'b0, 0, a0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder serving the load/store requests the pipeline MEM stage issues. It accepts one request at a time over a valid/ready channel and performs a byte-masked write or a 64-bit read on an internal word array. It returns a response after a configurable latency and holds it under backpressure. It lets the core run against RTL memory instead of host-side memory calls, and gives the MEM stage a real multi-cycle memory to stall on.

## Interface
Parameters:
- DEPTH, 4096: number of 64-bit words; power of two.
- BASE, 64'h8000_0000: byte address of word 0.
- LATENCY, 1: cycles from request acceptance to rsp_valid_o; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_wen_i  in  1  1 = write, 0 = read.
- req_addr_i  in  64  byte address; bits [2:0] are ignored.
- req_wdata_i  in  64  write data, lane-aligned.
- req_wmask_i  in  8  byte-lane write enables.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester takes the response.
- rsp_rdata_o  out  64  read data; 0 for writes and errors.
- rsp_err_o  out  1  address is outside [BASE, BASE+8*DEPTH).

## Operation
- FSM has three states: IDLE, WAIT and RESP. req_ready_o = (state == IDLE).
- Acceptance is req_valid_i && req_ready_o at a rising edge.
  - Word index = (req_addr_i - BASE) >> 3, truncated to log2(DEPTH) bits.
  - In-range write: each byte lane with its mask bit set takes req_wdata_i; other lanes are kept.
  - Mask 0: no change to the array.
  - In-range read: the full word is captured into the response register.
  - Out of range: no write, rdata = 0, err = 1.
  - All array effects commit at the acceptance edge.
- IDLE -> RESP on acceptance when LATENCY == 1. Otherwise IDLE -> WAIT, with the counter loaded to LATENCY-2.
- WAIT decrements the counter each cycle and moves to RESP when it reaches 0.
- In RESP, rsp_valid_o = 1. rsp_rdata_o and rsp_err_o are stable until rsp_valid_o && rsp_ready_i at an edge, then the FSM returns to IDLE.
- Only one transaction is outstanding, so there are no read-after-write hazards. A read issued after a write returns the written data.
- Reset, asserted at any time including mid-WAIT or mid-RESP, puts the FSM in IDLE and aborts the pending response.
  - Reset outputs: req_ready_o = 1, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, counter = 0.
  - Array contents are not reset.

## Timing
- Accept at edge N -> rsp_valid_o high from cycle N+LATENCY.
- After the response handshake at edge M, req_ready_o is high in cycle M+1.
- Peak throughput is one transaction per LATENCY+1 cycles.
- req_ready_o does not depend combinationally on req_valid_i.
- req_* inputs are sampled only at the acceptance edge.
- Address arithmetic is 64-bit unsigned. req_addr_i < BASE wraps to a huge offset and is therefore out of range.

## Configuration
- DMEM_TRACE_EN
  - Defined: each accepted request prints one $display line (simulation only, no effect on outputs) with:
    - cycle count
    - R/W
    - address
    - wdata and mask, or rdata
    - err
  - Undefined: no trace logic or cycle counter is compiled; the behaviour is identical otherwise.

## Structure
- dmem_pkg holds:
  - the state enum (IDLE/WAIT/RESP)
  - the default BASE
  - the word-size constants: 8 bytes, 3 offset bits
- Sub-module dmem_array: synchronous write with an 8-bit byte mask and a registered read port on the same edge. It contains the storage and nothing else.
- dmem_resp holds the FSM, latency counter, range check and response register.

## Test plan
- Reset check (LATENCY=1): hold rst low -> req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. Release, then write 0x1122334455667788, mask 0xFF, at 0x8000_0010 -> response one cycle later with rdata=0, err=0.
- Partial mask: write 0xAAAA_AAAA_AAAA_AAAA with mask 0x0F to 0x8000_0010, then read 0x8000_0014 -> rdata=0x11223344AAAAAAAA.
- Out of range: read 0x0000_1000 and write 0x8000_8000 (DEPTH=4096) -> err=1 and rdata=0 for both; a following read of 0x8000_0010 is unchanged.
- Backpressure: rsp_ready_i low for 5 cycles after rsp_valid_o rises -> rsp_valid_o, rsp_rdata_o and rsp_err_o stay stable and req_ready_o stays 0; the handshake is followed by req_ready_o=1 on the next cycle.
- Latency (LATENCY=3): accept at edge N -> rsp_valid_o first high in cycle N+3. Back-to-back requests are spaced exactly 4 cycles apart with rsp_ready_i tied to 1.
- Reset mid-WAIT (LATENCY=3): assert rst one cycle after acceptance -> rsp_valid_o=0 immediately and req_ready_o=1 after release. Data written before the reset is read back intact.
